// File: rtl/wb_regfile_if.sv
// wb_regfile_if: groups the MEM_WB bundle, load data, read ports and the
// external write handshake of wb_regfile.
//   i_c          MEM_WB bundle (all-zero = bubble)
//   i_mem_rdata  data memory read word aligned with i_c
//   i_ra1/i_ra2  read addresses;   o_rd1/o_rd2 read data
//   i_ext_*      external write request/address/data; o_ext_ack accept
//   o_wb_stall   one-cycle pipeline freeze on external-write starvation
//   o_retire_cnt committed pipeline write count
// Signal prefixes are from the register file's point of view.
interface wb_regfile_if #(
  parameter int unsigned N = 51
);
  logic [N:0]  i_c;
  logic [31:0] i_mem_rdata;
  logic [4:0]  i_ra1;
  logic [4:0]  i_ra2;
  logic [31:0] o_rd1;
  logic [31:0] o_rd2;
  logic        i_ext_req;
  logic [4:0]  i_ext_addr;
  logic [31:0] i_ext_data;
  logic        o_ext_ack;
  logic        o_wb_stall;
  logic [31:0] o_retire_cnt;

  modport master (
    output i_c, i_mem_rdata, i_ra1, i_ra2, i_ext_req, i_ext_addr, i_ext_data,
    input  o_rd1, o_rd2, o_ext_ack, o_wb_stall, o_retire_cnt
  );

  modport slave (
    input  i_c, i_mem_rdata, i_ra1, i_ra2, i_ext_req, i_ext_addr, i_ext_data,
    output o_rd1, o_rd2, o_ext_ack, o_wb_stall, o_retire_cnt
  );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage and 32x32 register file.
// Decodes the MEM_WB bundle, aligns/extends load data, commits the result,
// and arbitrates a secondary external write port against pipeline
// write-back. An external request that waits STARVE_MAX cycles raises
// o_wb_stall for one cycle so the pipeline inserts a bubble for it.
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  synchronous active-low reset
//   io_bus   wb_regfile_if slave (bundle, load data, read ports, ext port,
//            stall, retire count)
module wb_regfile #(
  parameter int unsigned N          = 51,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic        i_clk,
  input logic        i_rst_n,
  wb_regfile_if.slave io_bus
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

  logic [31:0]     r_regs [32];
  logic [31:0]     r_retire_cnt;
  logic [CntW-1:0] r_starve_cnt;
  logic            r_wb_stall;

  // Bundle decode
  logic        w_reg_write;
  logic        w_mem_to_reg;
  logic [4:0]  w_rd;
  logic [31:0] w_alu_result;
  logic [1:0]  w_size;
  logic        w_unsigned;
  logic [1:0]  w_off;
  logic        w_unused;

  assign w_reg_write  = io_bus.i_c[N];
  assign w_mem_to_reg = io_bus.i_c[N-1];
  assign w_rd         = io_bus.i_c[N-2 -: 5];
  assign w_alu_result = io_bus.i_c[N-7 -: 32];
  assign w_size       = io_bus.i_c[N-39 -: 2];
  assign w_unsigned   = io_bus.i_c[N-41];
  assign w_off        = io_bus.i_c[N-42 -: 2];
  assign w_unused     = ^io_bus.i_c[N-44:0];

  // Load alignment and extension
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_wb_data;

  always_comb begin
    w_byte = io_bus.i_mem_rdata[{w_off, 3'b000} +: 8];
    w_half = w_off[1] ? io_bus.i_mem_rdata[31:16] : io_bus.i_mem_rdata[15:0];
    case (w_size)
      2'b00:   w_load = {{24{~w_unsigned & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{~w_unsigned & w_half[15]}}, w_half};
      default: w_load = io_bus.i_mem_rdata;
    endcase
    w_wb_data = w_mem_to_reg ? w_load : w_alu_result;
  end

  // Arbitration: a pipeline write to r0 is not a write and never blocks ext.
  logic w_pw;
  logic w_ext_ack;
  logic w_ext_wr;

  assign w_pw      = i_rst_n & w_reg_write & (w_rd != 5'd0);
  assign w_ext_ack = i_rst_n & io_bus.i_ext_req & ~w_pw;
  assign w_ext_wr  = w_ext_ack & (io_bus.i_ext_addr != 5'd0);

  // Read ports with write-first bypass
  logic [31:0] w_rd1;
  logic [31:0] w_rd2;

  always_comb begin
    w_rd1 = r_regs[io_bus.i_ra1];
    if (io_bus.i_ra1 == 5'd0) begin
      w_rd1 = '0;
    end else if (w_pw && (io_bus.i_ra1 == w_rd)) begin
      w_rd1 = w_wb_data;
    end else if (w_ext_wr && (io_bus.i_ra1 == io_bus.i_ext_addr)) begin
      w_rd1 = io_bus.i_ext_data;
    end
  end

  always_comb begin
    w_rd2 = r_regs[io_bus.i_ra2];
    if (io_bus.i_ra2 == 5'd0) begin
      w_rd2 = '0;
    end else if (w_pw && (io_bus.i_ra2 == w_rd)) begin
      w_rd2 = w_wb_data;
    end else if (w_ext_wr && (io_bus.i_ra2 == io_bus.i_ext_addr)) begin
      w_rd2 = io_bus.i_ext_data;
    end
  end

  // Starvation counter saturates; the stall fires only on the cycle the
  // counter first reaches the limit, so it lasts exactly one cycle.
  logic [CntW-1:0] w_starve_d;
  logic            w_wb_stall_d;

  always_comb begin
    w_starve_d = '0;
    if (io_bus.i_ext_req && !w_ext_ack) begin
      w_starve_d = (r_starve_cnt == CntMax) ? r_starve_cnt : r_starve_cnt + 1'b1;
    end
    w_wb_stall_d = (w_starve_d == CntMax) && (r_starve_cnt != CntMax);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
      r_retire_cnt <= '0;
      r_starve_cnt <= '0;
      r_wb_stall   <= 1'b0;
    end else begin
      if (w_pw) begin
        r_regs[w_rd] <= w_wb_data;
        r_retire_cnt <= r_retire_cnt + 32'd1;
      end else if (w_ext_wr) begin
        r_regs[io_bus.i_ext_addr] <= io_bus.i_ext_data;
      end
      r_starve_cnt <= w_starve_d;
      r_wb_stall   <= w_wb_stall_d;
    end
  end

  assign io_bus.o_rd1        = w_rd1;
  assign io_bus.o_rd2        = w_rd2;
  assign io_bus.o_ext_ack    = w_ext_ack;
  assign io_bus.o_wb_stall   = r_wb_stall;
  assign io_bus.o_retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed steps followed by random
// traffic, checked against an array-based reference model.
module tb_wb_regfile;
  localparam int N          = 51;
  localparam int STARVE_MAX = 4;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  wb_regfile_if #(.N(N)) bus ();

  wb_regfile #(.N(N), .STARVE_MAX(STARVE_MAX)) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .io_bus (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Stimulus fields
  logic        s_rw, s_m2r, s_uns, s_req;
  logic [4:0]  s_rd, s_ea, s_ra1, s_ra2;
  logic [1:0]  s_size, s_off;
  logic [7:0]  s_low;
  logic [31:0] s_alu, s_mem, s_ed;

  // Reference model
  logic [31:0] m_regs [32];
  logic [31:0] m_retire;
  int          m_wait;  // consecutive unacked request cycles, unsaturated

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] size,
                                         input logic uns, input logic [1:0] off);
    longint v;
    int     bits;
    if (size == 2'd0) begin
      bits = 8;
      v = longint'((w >> (8 * int'(off))) & 32'hFF);
    end else if (size == 2'd1) begin
      bits = 16;
      v = longint'((w >> ((off >= 2'd2) ? 16 : 0)) & 32'hFFFF);
    end else begin
      return w;
    end
    if (!uns && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
    return v[31:0];
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input bit pw, input bit ack,
                                         input logic [31:0] wbd);
    if (a == 5'd0) return 32'd0;
    if (pw && a == s_rd) return wbd;
    if (ack && a == s_ea) return s_ed;
    return m_regs[a];
  endfunction

  task automatic apply();
    bus.i_c         = {s_rw, s_m2r, s_rd, s_alu, s_size, s_uns, s_off, s_low};
    bus.i_mem_rdata = s_mem;
    bus.i_ra1       = s_ra1;
    bus.i_ra2       = s_ra2;
    bus.i_ext_req   = s_req;
    bus.i_ext_addr  = s_ea;
    bus.i_ext_data  = s_ed;
    #1;
  endtask

  task automatic set_bubble();
    s_rw = 0; s_m2r = 0; s_rd = 0; s_alu = 0; s_size = 0; s_uns = 0; s_off = 0; s_low = 0;
  endtask

  task automatic set_pw(input logic [4:0] rd, input logic [31:0] alu);
    set_bubble();
    s_rw = 1; s_rd = rd; s_alu = alu;
  endtask

  task automatic set_load(input logic [1:0] size, input logic uns, input logic [1:0] off);
    set_bubble();
    s_rw = 1; s_m2r = 1; s_rd = 5'd3; s_alu = 32'hCAFEF00D;
    s_size = size; s_uns = uns; s_off = off; s_mem = 32'h80FF7F01;
  endtask

  // One clock: check outputs mid-cycle against the model, then commit model.
  task automatic cycle(input string tag);
    bit          pw, ack;
    logic [31:0] wbd;
    wbd = s_m2r ? m_load(s_mem, s_size, s_uns, s_off) : s_alu;
    pw  = i_rst_n && s_rw && s_rd != 5'd0;
    ack = i_rst_n && s_req && !pw;
    @(negedge i_clk);
    chk({tag, "/ack"}, 32'(bus.o_ext_ack), 32'(ack));
    if (i_rst_n) begin
      chk({tag, "/rd1"}, bus.o_rd1, m_read(s_ra1, pw, ack, wbd));
      chk({tag, "/rd2"}, bus.o_rd2, m_read(s_ra2, pw, ack, wbd));
      chk({tag, "/stall"}, 32'(bus.o_wb_stall), 32'(m_wait == STARVE_MAX));
      chk({tag, "/retire"}, bus.o_retire_cnt, m_retire);
    end
    @(posedge i_clk);
    if (!i_rst_n) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_retire = 32'd0;
      m_wait = 0;
    end else begin
      if (pw) begin
        m_regs[s_rd] = wbd;
        m_retire = m_retire + 32'd1;
      end else if (ack && s_ea != 5'd0) begin
        m_regs[s_ea] = s_ed;
      end
      if (s_req && !ack) m_wait++;
      else m_wait = 0;
    end
    #1;
  endtask

  initial begin
    logic [31:0] r;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_retire = 32'd0;
    m_wait = 0;

    // Reset
    set_bubble();
    s_mem = 0; s_req = 0; s_ea = 0; s_ed = 0; s_ra1 = 0; s_ra2 = 0;
    apply();
    cycle("rst0");
    cycle("rst1");
    i_rst_n = 1'b1;
    s_ra1 = 5'd5; s_ra2 = 5'd31;
    apply();
    chk("rst_retire", bus.o_retire_cnt, 32'd0);
    chk("rst_stall", 32'(bus.o_wb_stall), 32'd0);
    chk("rst_reg5", bus.o_rd1, 32'd0);
    chk("rst_reg31", bus.o_rd2, 32'd0);

    // ALU write-back
    set_pw(5'd5, 32'h12345678); apply();
    chk("alu_bypass", bus.o_rd1, 32'h12345678);
    cycle("alu");
    set_bubble(); apply();
    chk("alu_array", bus.o_rd1, 32'h12345678);
    chk("alu_retire", bus.o_retire_cnt, 32'd1);
    cycle("alu_idle");

    // Load extension
    s_ra1 = 5'd3;
    set_load(2'd0, 1'b0, 2'd3); apply(); chk("ld_sb3", bus.o_rd1, 32'hFFFFFF80); cycle("ld_sb3");
    set_load(2'd0, 1'b1, 2'd3); apply(); chk("ld_ub3", bus.o_rd1, 32'h00000080); cycle("ld_ub3");
    set_load(2'd1, 1'b0, 2'd2); apply(); chk("ld_sh2", bus.o_rd1, 32'hFFFF80FF); cycle("ld_sh2");
    set_load(2'd1, 1'b0, 2'd3); apply(); chk("ld_sh3", bus.o_rd1, 32'hFFFF80FF); cycle("ld_sh3");
    set_load(2'd0, 1'b0, 2'd0); apply(); chk("ld_sb0", bus.o_rd1, 32'h00000001); cycle("ld_sb0");
    set_load(2'd1, 1'b1, 2'd0); apply(); chk("ld_uh0", bus.o_rd1, 32'h00007F01); cycle("ld_uh0");
    set_load(2'd3, 1'b0, 2'd1); apply(); chk("ld_w11", bus.o_rd1, 32'h80FF7F01); cycle("ld_w11");
    set_bubble(); apply(); chk("ld_array", bus.o_rd1, 32'h80FF7F01); cycle("ld_idle");

    // Register 0 protection
    s_ra1 = 5'd0;
    set_pw(5'd0, 32'hDEADBEEF); apply(); chk("r0_pw_read", bus.o_rd1, 32'd0); cycle("r0_pw");
    set_bubble(); s_req = 1; s_ea = 5'd0; s_ed = 32'hFFFFFFFF; apply();
    chk("r0_retire", bus.o_retire_cnt, 32'd8);
    chk("r0_ext_ack", 32'(bus.o_ext_ack), 32'd1);
    chk("r0_ext_read", bus.o_rd1, 32'd0);
    cycle("r0_ext");

    // Arbitration
    s_req = 1; s_ea = 5'd7; s_ed = 32'hA5A5A5A5; s_ra1 = 5'd7; apply();
    chk("arb_ack", 32'(bus.o_ext_ack), 32'd1);
    chk("arb_bypass", bus.o_rd1, 32'hA5A5A5A5);
    cycle("arb_ext");
    s_req = 0; apply(); chk("arb_array", bus.o_rd1, 32'hA5A5A5A5); cycle("arb_idle");
    set_pw(5'd7, 32'h1); s_req = 1; s_ed = 32'h5A5A5A5A; apply();
    chk("arb_conf_ack", 32'(bus.o_ext_ack), 32'd0);
    chk("arb_conf_rd", bus.o_rd1, 32'h1);
    cycle("arb_conf");
    set_pw(5'd9, 32'h99); apply();
    chk("arb_wait_ack", 32'(bus.o_ext_ack), 32'd0);
    chk("arb_pw_won", bus.o_rd1, 32'h1);
    cycle("arb_wait");
    set_bubble(); apply();
    chk("arb_late_ack", 32'(bus.o_ext_ack), 32'd1);
    cycle("arb_late");
    s_req = 0; apply(); chk("arb_late_val", bus.o_rd1, 32'h5A5A5A5A); cycle("arb_done");

    // Starvation
    s_req = 1; s_ea = 5'd12; s_ed = 32'h12121212;
    for (int i = 0; i < STARVE_MAX; i++) begin
      set_pw(5'd10, 32'(i)); apply();
      chk("starve_nostall", 32'(bus.o_wb_stall), 32'd0);
      cycle("starve");
    end
    chk("starve_stall", 32'(bus.o_wb_stall), 32'd1);
    chk("starve_noack", 32'(bus.o_ext_ack), 32'd0);
    cycle("starve_hold");
    set_bubble(); apply();
    chk("starve_drop", 32'(bus.o_wb_stall), 32'd0);
    chk("starve_ack", 32'(bus.o_ext_ack), 32'd1);
    cycle("starve_bubble");
    // Counter restarted from zero: a second full wait stalls again, once.
    s_ea = 5'd13; s_ed = 32'h13131313;
    set_pw(5'd11, 32'h11); apply();
    for (int i = 0; i < STARVE_MAX; i++) cycle("starve2");
    chk("starve2_stall", 32'(bus.o_wb_stall), 32'd1);
    cycle("starve2_hold");
    chk("starve2_pend_drop", 32'(bus.o_wb_stall), 32'd0);
    cycle("starve2_pend");
    chk("starve2_sat", 32'(bus.o_wb_stall), 32'd0);
    set_bubble(); apply();
    chk("starve2_ack", 32'(bus.o_ext_ack), 32'd1);
    cycle("starve2_bubble");
    s_req = 0; apply(); cycle("starve_idle");

    // Reset mid-operation
    set_pw(5'd4, 32'h77); s_req = 1; s_ea = 5'd8; s_ed = 32'h88;
    i_rst_n = 1'b0; apply();
    chk("mrst_ack", 32'(bus.o_ext_ack), 32'd0);
    cycle("mrst");
    i_rst_n = 1'b1; set_bubble(); s_req = 0; apply();
    chk("mrst_retire", bus.o_retire_cnt, 32'd0);
    chk("mrst_stall", 32'(bus.o_wb_stall), 32'd0);
    for (int a = 0; a < 32; a += 2) begin
      s_ra1 = 5'(a); s_ra2 = 5'(a + 1); apply();
      chk("mrst_reg", bus.o_rd1, 32'd0);
      chk("mrst_reg", bus.o_rd2, 32'd0);
      cycle("mrst_scan");
    end

    // Random traffic
    for (int it = 0; it < 500; it++) begin
      r = $urandom;
      s_rw   = (r[1:0] != 2'd0);
      s_m2r  = r[2];
      s_size = r[4:3];
      s_uns  = r[5];
      s_off  = r[7:6];
      s_rd   = r[12:8];
      s_req  = r[13];
      s_ea   = r[18:14];
      s_low  = r[26:19];
      i_rst_n = (r[31:27] != 5'd0) || (it < 5);
      s_alu = $urandom;
      s_mem = $urandom;
      s_ed  = $urandom;
      r = $urandom;
      s_ra1 = r[0] ? s_rd : r[5:1];
      s_ra2 = r[6] ? s_ea : r[11:7];
      apply();
      cycle("rand");
    end
    i_rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
